// File: rtl/matrix_operand_loader.sv
// Serial-to-matrix operand loader: packs row-major 16-bit elements into two 4x4
// operands (A, B) and delivers them in order on a registered 256-bit handshake.
module matrix_operand_loader #(
    parameter int WORD_W = 16,
    parameter int DIM    = 4,
    parameter int MAT_W  = DIM * DIM * WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] wordIn,
    input  logic              wordValid,
    output logic              wordReady,
    input  logic              abort,
    output logic [MAT_W-1:0]  matOut,
    output logic              matValid,
    output logic              matSel,
    input  logic              matReady,
    output logic [15:0]       pairCount
);

    localparam int NELEM = DIM * DIM;
    localparam int CNT_W = $clog2(NELEM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NELEM - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SEND_A = 2'd2,
        SEND_B = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   elemCnt_r;
    logic [MAT_W-1:0]   bufA_r;
    logic [MAT_W-1:0]   bufB_r;
    logic [MAT_W-1:0]   matOut_r;
    logic               matValid_r;
    logic               matSel_r;
    logic [15:0]        pairCount_r;

    logic               loading_s;
    logic               wordAccept_s;
    logic               matAccept_s;

    // Upstream and downstream handshake decode.
    always_comb begin
        loading_s    = (state_r == LOAD_A) || (state_r == LOAD_B);
        wordReady    = loading_s && !rst && !abort;
        wordAccept_s = wordValid && wordReady;
        matAccept_s  = matValid_r && matReady;
    end

    // Loader FSM, element buffers and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= LOAD_A;
            elemCnt_r   <= '0;
            bufA_r      <= '0;
            bufB_r      <= '0;
            matOut_r    <= '0;
            matValid_r  <= 1'b0;
            matSel_r    <= 1'b0;
            pairCount_r <= 16'd0;
        end else if (abort) begin
            // Buffers are left as-is; a reload overwrites every element anyway.
            state_r    <= LOAD_A;
            elemCnt_r  <= '0;
            matValid_r <= 1'b0;
            matSel_r   <= 1'b0;
        end else begin
            case (state_r)
                LOAD_A: begin
                    if (wordAccept_s) begin
                        for (int k = 0; k < NELEM; k++) begin
                            if (elemCnt_r == CNT_W'(k)) begin
                                bufA_r[k*WORD_W +: WORD_W] <= wordIn;
                            end
                        end
                        elemCnt_r <= elemCnt_r + CNT_W'(1);
                        if (elemCnt_r == LAST_IDX) begin
                            state_r <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (wordAccept_s) begin
                        for (int k = 0; k < NELEM; k++) begin
                            if (elemCnt_r == CNT_W'(k)) begin
                                bufB_r[k*WORD_W +: WORD_W] <= wordIn;
                            end
                        end
                        elemCnt_r <= elemCnt_r + CNT_W'(1);
                        // A is already complete, so it can be presented on the same edge.
                        if (elemCnt_r == LAST_IDX) begin
                            state_r    <= SEND_A;
                            matOut_r   <= bufA_r;
                            matValid_r <= 1'b1;
                            matSel_r   <= 1'b0;
                        end
                    end
                end
                SEND_A: begin
                    if (matAccept_s) begin
                        matOut_r <= bufB_r;
                        matSel_r <= 1'b1;
                        state_r  <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (matAccept_s) begin
                        matValid_r  <= 1'b0;
                        matSel_r    <= 1'b0;
                        pairCount_r <= pairCount_r + 16'd1;
                        state_r     <= LOAD_A;
                    end
                end
                default: begin
                    state_r    <= LOAD_A;
                    elemCnt_r  <= '0;
                    matValid_r <= 1'b0;
                    matSel_r   <= 1'b0;
                end
            endcase
        end
    end

    assign matOut    = matOut_r;
    assign matValid  = matValid_r;
    assign matSel    = matSel_r;
    assign pairCount = pairCount_r;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed scenario table, hand-written corner
// sequences and random traffic, all checked against a transaction-level model.
module tb_matrix_operand_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  wordIn;
    logic         wordValid;
    logic         wordReady;
    logic         abort;
    logic [255:0] matOut;
    logic         matValid;
    logic         matSel;
    logic         matReady;
    logic [15:0]  pairCount;

    always #5 clk = ~clk;

    matrix_operand_loader dut (
        .clk       (clk),
        .rst       (rst),
        .wordIn    (wordIn),
        .wordValid (wordValid),
        .wordReady (wordReady),
        .abort     (abort),
        .matOut    (matOut),
        .matValid  (matValid),
        .matSel    (matSel),
        .matReady  (matReady),
        .pairCount (pairCount)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: words taken so far (0..32), then two output beats.
    logic [15:0]  stim [32];
    logic [15:0]  mElem [32];
    int           mTaken;
    bit           mSending;
    bit           mValid;
    bit           mSel;
    logic [255:0] mOut;
    logic [15:0]  mPairs;

    typedef struct {
        string       name;
        bit          gap;
        int          stall;
        logic [15:0] expA0;
        logic [15:0] expA5;
        logic [15:0] expB15;
        logic [15:0] expB0;
        logic [15:0] expPairs;
    } scen_t;

    scen_t scen [4];

    function automatic logic [255:0] packMat(input int base);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[i*64 + 16*j +: 16] = mElem[base + 4*i + j];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelEdge(input bit r, input bit a, input bit wv, input logic [15:0] w, input bit mr);
        if (r) begin
            mTaken = 0; mSending = 1'b0; mValid = 1'b0; mSel = 1'b0; mOut = '0; mPairs = 16'd0;
        end else if (a) begin
            mTaken = 0; mSending = 1'b0; mValid = 1'b0; mSel = 1'b0;
        end else if (!mSending) begin
            if (wv) begin
                mElem[mTaken] = w;
                mTaken++;
                if (mTaken == 32) begin
                    mSending = 1'b1; mValid = 1'b1; mSel = 1'b0; mOut = packMat(0);
                end
            end
        end else if (mr) begin
            if (!mSel) begin
                mSel = 1'b1; mOut = packMat(16);
            end else begin
                mValid = 1'b0; mSel = 1'b0; mSending = 1'b0; mTaken = 0;
                mPairs = mPairs + 16'd1;
            end
        end
    endtask

    // One clock: drive after the falling edge, check ready before the rising edge,
    // check registered outputs at the next falling edge.
    task automatic step(input bit r, input bit a, input bit wv, input logic [15:0] w, input bit mr);
        rst = r; abort = a; wordValid = wv; wordIn = w; matReady = mr;
        #1;
        chk("wordReady", 256'(wordReady), 256'(!r && !a && !mSending));
        @(posedge clk);
        modelEdge(r, a, wv, w, mr);
        @(negedge clk);
        chk("matValid", 256'(matValid), 256'(mValid));
        chk("matSel", 256'(matSel), 256'(mSel));
        chk("matOut", matOut, mOut);
        chk("pairCount", 256'(pairCount), 256'(mPairs));
    endtask

    task automatic feed(input int target, input bit gap);
        bit phase;
        int guard;
        phase = 1'b0;
        guard = 0;
        while (mTaken < target && guard < 200) begin
            if (gap && phase) step(1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
            else              step(1'b0, 1'b0, 1'b1, stim[mTaken], 1'b0);
            phase = !phase;
            guard++;
        end
    endtask

    task automatic randStim();
        for (int n = 0; n < 32; n++) stim[n] = 16'($urandom);
    endtask

    initial begin
        logic [15:0] savedPairs;

        rst = 1'b1; abort = 1'b0; wordValid = 1'b0; wordIn = 16'd0; matReady = 1'b0;
        mTaken = 0; mSending = 1'b0; mValid = 1'b0; mSel = 1'b0; mOut = '0; mPairs = 16'd0;

        scen[0] = '{"no_backpressure", 1'b0, 0, 16'h0001, 16'h0001, 16'h0010, 16'h0001, 16'd1};
        scen[1] = '{"stall5",          1'b0, 5, 16'h0001, 16'h0001, 16'h0010, 16'h0001, 16'd2};
        scen[2] = '{"input_gaps",      1'b1, 0, 16'h0001, 16'h0001, 16'h0010, 16'h0001, 16'd3};
        scen[3] = '{"gaps_stall3",     1'b1, 3, 16'h0001, 16'h0001, 16'h0010, 16'h0001, 16'd4};

        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        chk("reset_matValid", 256'(matValid), 256'(1'b0));
        chk("reset_matOut", matOut, 256'd0);
        chk("reset_pairCount", 256'(pairCount), 256'(16'd0));

        // Identity A, B element n = n+1, under different gap/stall patterns.
        for (int n = 0; n < 16; n++) stim[n] = (n % 5 == 0) ? 16'h0001 : 16'h0000;
        for (int n = 16; n < 32; n++) stim[n] = 16'(n - 15);
        for (int s = 0; s < 4; s++) begin
            feed(32, scen[s].gap);
            chk({scen[s].name, "_A_valid"}, 256'(matValid), 256'(1'b1));
            chk({scen[s].name, "_A_e00"}, 256'(matOut[15:0]), 256'(scen[s].expA0));
            chk({scen[s].name, "_A_e11"}, 256'(matOut[95:80]), 256'(scen[s].expA5));
            chk({scen[s].name, "_A_sel"}, 256'(matSel), 256'(1'b0));
            for (int c = 0; c < scen[s].stall; c++) begin
                step(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
                chk({scen[s].name, "_stall_sel"}, 256'(matSel), 256'(1'b0));
                chk({scen[s].name, "_stall_e00"}, 256'(matOut[15:0]), 256'(scen[s].expA0));
            end
            step(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
            chk({scen[s].name, "_B_e33"}, 256'(matOut[255:240]), 256'(scen[s].expB15));
            chk({scen[s].name, "_B_e00"}, 256'(matOut[15:0]), 256'(scen[s].expB0));
            chk({scen[s].name, "_B_sel"}, 256'(matSel), 256'(1'b1));
            step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
            chk({scen[s].name, "_pairs"}, 256'(pairCount), 256'(scen[s].expPairs));
        end

        // Abort after 7 words of B, then a fresh pair.
        randStim();
        savedPairs = mPairs;
        feed(23, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
        chk("abort_matValid", 256'(matValid), 256'(1'b0));
        wordValid = 1'b0; abort = 1'b0;
        #1;
        chk("abort_wordReady", 256'(wordReady), 256'(1'b1));
        randStim();
        feed(32, 1'b0);
        chk("abort_pairs_kept", 256'(pairCount), 256'(savedPairs));
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        chk("abort_reload_pairs", 256'(pairCount), 256'(savedPairs + 16'd1));

        // Abort together with matReady in SEND_B.
        randStim();
        feed(32, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        savedPairs = mPairs;
        step(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
        chk("abortB_pairs", 256'(pairCount), 256'(savedPairs));
        chk("abortB_valid", 256'(matValid), 256'(1'b0));

        // Reset while B is being presented.
        randStim();
        feed(32, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        chk("rstB_pairs", 256'(pairCount), 256'(16'd0));
        chk("rstB_matOut", matOut, 256'd0);
        chk("rstB_sel", 256'(matSel), 256'(1'b0));

        // pairCount wrap via backdoor preload.
        randStim();
        feed(5, 1'b0);
        force dut.pairCount_r = 16'hFFFF;
        #1;
        release dut.pairCount_r;
        mPairs = 16'hFFFF;
        feed(32, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        chk("wrap_pairs", 256'(pairCount), 256'(16'h0000));

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
